// File: rtl/dco_tune_ctrl.sv
// dco_tune_ctrl: sequences DCO stop/retune requests from two requesters
// (0 = software SFR path, 1 = hardware power manager, 1 has priority). It
// drives the SFR hardware-update ports for dco_ctrl and dco_cnt so that the DCO
// is stopped, settled, reprogrammed and restarted without runt pulses.
//
// Handshake: reqX_valid rises with en/dcnt stable and stays high until
// reqX_ack. reqX_ack is a one-cycle pulse issued in DONE. en/dcnt are captured
// at grant. A valid that is still high in the first IDLE cycle after its ack
// is treated as a new request.
//
// Field layout assumed for the SFR words: dco_ctrl.on is bit 0 and dco_cnt.dcnt
// occupies bits [N-1:0]. All other bits are neither read nor written.
module dco_tune_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 20,
   parameter int SETTLE_CYC = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [DATA_WIDTH-1:0] dco_ctrl,
   input  logic [DATA_WIDTH-1:0] dco_cnt,
   input  logic                  dco_clk_out,
   input  logic                  req0_valid,
   input  logic                  req0_en,
   input  logic [N-1:0]          req0_dcnt,
   input  logic                  req1_valid,
   input  logic                  req1_en,
   input  logic [N-1:0]          req1_dcnt,
   output logic                  req0_ack,
   output logic                  req1_ack,
   output logic                  busy,
   output logic                  tune_err,
   output logic [DATA_WIDTH-1:0] hw_up_dco_ctrl,
   output logic [DATA_WIDTH-1:0] hw_val_dco_ctrl,
   output logic [DATA_WIDTH-1:0] hw_up_dco_cnt,
   output logic [DATA_WIDTH-1:0] hw_val_dco_cnt,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DISABLE   = 3'd1,
      S_SETTLE    = 3'd2,
      S_LOAD      = 3'd3,
      S_ENABLE    = 3'd4,
      S_WAIT_EDGE = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   localparam logic [DATA_WIDTH-1:0] ON_MASK   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DCNT_MASK = {{(DATA_WIDTH-N){1'b0}}, {N{1'b1}}};
   localparam logic [7:0]            SETTLE_LAST = 8'(SETTLE_CYC - 1);
   // 2^(N+1): long enough for a stale counter above the new dcnt to wrap
   localparam logic [N+1:0]          WAIT_LIMIT  = {2'b10, {N{1'b0}}};
   localparam logic [N+1:0]          WAIT_ONE    = {{(N+1){1'b0}}, 1'b1};

   state_t         state, state_n;
   logic           gid, gid_n;
   logic           cap_en, cap_en_n;
   logic [N-1:0]   cap_dcnt, cap_dcnt_n;
   logic [7:0]     scnt, scnt_n;
   logic [N+1:0]   wcnt, wcnt_n;
   logic           err_n;
   logic           clk_q;

   logic           dco_on;
   logic [N-1:0]   cur_dcnt;
   logic           any_valid;
   logic           sel_en;
   logic [N-1:0]   sel_dcnt;
   logic           unused_bits;

   assign dco_on      = dco_ctrl[0];
   assign cur_dcnt    = dco_cnt[N-1:0];
   assign any_valid   = req0_valid | req1_valid;
   assign sel_en      = req1_valid ? req1_en   : req0_en;
   assign sel_dcnt    = req1_valid ? req1_dcnt : req0_dcnt;
   assign unused_bits = ^{dco_ctrl[DATA_WIDTH-1:1], dco_cnt[DATA_WIDTH-1:N]};
   assign state_dbg   = state;

   // Next-state, capture and counter logic
   always_comb begin
      state_n    = state;
      gid_n      = gid;
      cap_en_n   = cap_en;
      cap_dcnt_n = cap_dcnt;
      scnt_n     = scnt;
      wcnt_n     = wcnt;
      err_n      = tune_err;
      case (state)
         S_IDLE: begin
            if (any_valid) begin
               gid_n      = req1_valid;
               cap_en_n   = sel_en;
               cap_dcnt_n = sel_dcnt;
               err_n      = 1'b0;
               scnt_n     = '0;
               wcnt_n     = '0;
               if (sel_en) begin
                  if (dco_on && (cur_dcnt == sel_dcnt)) state_n = S_DONE;
                  else if (dco_on)                      state_n = S_DISABLE;
                  else                                  state_n = S_LOAD;
               end else begin
                  state_n = dco_on ? S_DISABLE : S_DONE;
               end
            end
         end
         S_DISABLE: begin
            scnt_n  = '0;
            state_n = S_SETTLE;
         end
         S_SETTLE: begin
            if (scnt == SETTLE_LAST) state_n = cap_en ? S_LOAD : S_DONE;
            else                     scnt_n  = scnt + 8'd1;
         end
         S_LOAD: begin
            state_n = S_ENABLE;
         end
         S_ENABLE: begin
            wcnt_n  = '0;
            state_n = S_WAIT_EDGE;
         end
         S_WAIT_EDGE: begin
            wcnt_n = wcnt + WAIT_ONE;
            if (dco_clk_out != clk_q) begin
               state_n = S_DONE;
            end else if ((wcnt + WAIT_ONE) == WAIT_LIMIT) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State, capture and counter registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= S_IDLE;
         gid      <= 1'b0;
         cap_en   <= 1'b0;
         cap_dcnt <= '0;
         scnt     <= '0;
         wcnt     <= '0;
         tune_err <= 1'b0;
         clk_q    <= 1'b0;
      end else begin
         state    <= state_n;
         gid      <= gid_n;
         cap_en   <= cap_en_n;
         cap_dcnt <= cap_dcnt_n;
         scnt     <= scnt_n;
         wcnt     <= wcnt_n;
         tune_err <= err_n;
         clk_q    <= dco_clk_out;
      end
   end

   // Registered outputs, decoded from the state being entered
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         busy            <= 1'b0;
         req0_ack        <= 1'b0;
         req1_ack        <= 1'b0;
         hw_up_dco_ctrl  <= '0;
         hw_val_dco_ctrl <= '0;
         hw_up_dco_cnt   <= '0;
         hw_val_dco_cnt  <= '0;
      end else begin
         busy            <= (state_n != S_IDLE);
         req0_ack        <= (state_n == S_DONE) && !gid_n;
         req1_ack        <= (state_n == S_DONE) &&  gid_n;
         hw_up_dco_ctrl  <= ((state_n == S_DISABLE) || (state_n == S_ENABLE)) ? ON_MASK : '0;
         hw_val_dco_ctrl <= (state_n == S_ENABLE) ? ON_MASK : '0;
         hw_up_dco_cnt   <= (state_n == S_LOAD) ? DCNT_MASK : '0;
         hw_val_dco_cnt  <= (state_n == S_LOAD) ? {{(DATA_WIDTH-N){1'b0}}, cap_dcnt_n} : '0;
      end
   end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// tb_dco_tune_ctrl: directed bench for dco_tune_ctrl with N=4, SETTLE_CYC=4.
// Includes a small SFR + DCO model so restart edges come from real behaviour.
module tb_dco_tune_ctrl;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int S  = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          req0_valid = 1'b0, req0_en = 1'b0;
   logic [N-1:0]  req0_dcnt = '0;
   logic          req1_valid = 1'b0, req1_en = 1'b0;
   logic [N-1:0]  req1_dcnt = '0;
   logic          req0_ack, req1_ack, busy, tune_err;
   logic [DW-1:0] hw_up_dco_ctrl, hw_val_dco_ctrl, hw_up_dco_cnt, hw_val_dco_cnt;
   logic [2:0]    state_dbg;

   // SFR and DCO model
   logic [DW-1:0] sfr_ctrl = 32'h1;
   logic [DW-1:0] sfr_cnt  = 32'h3;
   logic [N-1:0]  dco_q    = '0;
   logic          dco_out  = 1'b0;
   logic          sys_clk_en = 1'b1;
   logic          preset_go = 1'b0;
   logic [N-1:0]  preset_val = '0;

   int assertions = 0;
   int failures   = 0;

   dco_tune_ctrl #(.DATA_WIDTH(DW), .N(N), .SETTLE_CYC(S)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .dco_ctrl(sfr_ctrl), .dco_cnt(sfr_cnt), .dco_clk_out(dco_out),
      .req0_valid(req0_valid), .req0_en(req0_en), .req0_dcnt(req0_dcnt),
      .req1_valid(req1_valid), .req1_en(req1_en), .req1_dcnt(req1_dcnt),
      .req0_ack(req0_ack), .req1_ack(req1_ack), .busy(busy), .tune_err(tune_err),
      .hw_up_dco_ctrl(hw_up_dco_ctrl), .hw_val_dco_ctrl(hw_val_dco_ctrl),
      .hw_up_dco_cnt(hw_up_dco_cnt), .hw_val_dco_cnt(hw_val_dco_cnt),
      .state_dbg(state_dbg)
   );

   // Clock
   always #5 sys_clk = ~sys_clk;

   // SFR hardware update and DCO half-period counter
   always @(posedge sys_clk) begin
      sfr_ctrl <= (sfr_ctrl & ~hw_up_dco_ctrl) | (hw_val_dco_ctrl & hw_up_dco_ctrl);
      sfr_cnt  <= (sfr_cnt  & ~hw_up_dco_cnt)  | (hw_val_dco_cnt  & hw_up_dco_cnt);
      if (preset_go) begin
         dco_q <= preset_val;
      end else if (sfr_ctrl[0] && sys_clk_en) begin
         if (dco_q == sfr_cnt[N-1:0]) begin
            dco_out <= ~dco_out;
            dco_q   <= '0;
         end else begin
            dco_q <= dco_q + 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertions++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits up to budget cycles for the selected ack, then checks it was seen
   task automatic wait_ack(input string tag, input int budget, input bit which);
      int cyc;
      logic seen;
      cyc  = 0;
      seen = 1'b0;
      while (cyc < budget && !seen) begin
         step();
         cyc++;
         seen = which ? req1_ack : req0_ack;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   // Counts cycles until dco_out changes (bounded)
   task automatic toggle_gap(input int budget, output int gap);
      logic prev;
      prev = dco_out;
      gap  = 0;
      while (gap < budget && dco_out == prev) begin
         step();
         gap++;
      end
   endtask

   initial begin
      int gap;

      // Reset values
      step(); step();
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(tune_err), 32'd0);
      check("rst_ack", 32'({req1_ack, req0_ack}), 32'd0);
      check("rst_up_ctrl", hw_up_dco_ctrl, 32'd0);
      check("rst_val_ctrl", hw_val_dco_ctrl, 32'd0);
      check("rst_up_cnt", hw_up_dco_cnt, 32'd0);
      check("rst_val_cnt", hw_val_dco_cnt, 32'd0);
      sys_rst_n = 1'b1;
      repeat (3) step();

      // Retune from on: dcnt 3 -> 1
      req0_valid = 1'b1; req0_en = 1'b1; req0_dcnt = 4'd1;
      step();                                          // T+1
      check("rt_dis_state", 32'(state_dbg), 32'd1);
      check("rt_dis_up", hw_up_dco_ctrl, 32'h1);
      check("rt_dis_val", hw_val_dco_ctrl, 32'h0);
      check("rt_dis_upcnt", hw_up_dco_cnt, 32'h0);
      check("rt_dis_busy", 32'(busy), 32'd1);
      step();                                          // T+2
      check("rt_set_state", 32'(state_dbg), 32'd2);
      check("rt_set_up", hw_up_dco_ctrl, 32'h0);
      step(); step(); step();                          // T+5
      check("rt_set_last", 32'(state_dbg), 32'd2);
      step();                                          // T+6
      check("rt_load_state", 32'(state_dbg), 32'd3);
      check("rt_load_up", hw_up_dco_cnt, 32'hF);
      check("rt_load_val", hw_val_dco_cnt, 32'h1);
      check("rt_load_upctrl", hw_up_dco_ctrl, 32'h0);
      step();                                          // T+7
      check("rt_en_state", 32'(state_dbg), 32'd4);
      check("rt_en_up", hw_up_dco_ctrl, 32'h1);
      check("rt_en_val", hw_val_dco_ctrl, 32'h1);
      check("rt_en_upcnt", hw_up_dco_cnt, 32'h0);
      step();                                          // T+8
      check("rt_wait_state", 32'(state_dbg), 32'd5);
      wait_ack("rt_ack", 40, 1'b0);
      check("rt_ack_err", 32'(tune_err), 32'd0);
      check("rt_ack_other", 32'(req1_ack), 32'd0);
      step();                                          // ack+1: drop valid
      req0_valid = 1'b0;
      check("rt_idle_busy", 32'(busy), 32'd0);
      check("rt_idle_ack", 32'(req0_ack), 32'd0);
      step();
      check("rt_no_regrant", 32'(state_dbg), 32'd0);
      toggle_gap(20, gap);
      toggle_gap(10, gap);
      check("rt_half_period_a", 32'(gap), 32'd2);
      toggle_gap(10, gap);
      check("rt_half_period_b", 32'(gap), 32'd2);

      // Fast path: req1 en=1 with the current dcnt while on
      req1_valid = 1'b1; req1_en = 1'b1; req1_dcnt = 4'd1;
      step();
      check("fp_ack1", 32'(req1_ack), 32'd1);
      check("fp_ack0", 32'(req0_ack), 32'd0);
      check("fp_state", 32'(state_dbg), 32'd6);
      check("fp_busy", 32'(busy), 32'd1);
      check("fp_up_ctrl", hw_up_dco_ctrl, 32'h0);
      check("fp_up_cnt", hw_up_dco_cnt, 32'h0);
      req1_valid = 1'b0;
      step();
      check("fp_idle", 32'(state_dbg), 32'd0);
      check("fp_idle_busy", 32'(busy), 32'd0);
      check("fp_ack_gone", 32'(req1_ack), 32'd0);

      // Simultaneous requests: req1 first, then req0 (fast path)
      req0_valid = 1'b1; req0_en = 1'b1; req0_dcnt = 4'd2;
      req1_valid = 1'b1; req1_en = 1'b1; req1_dcnt = 4'd2;
      step();
      check("both_dis", 32'(state_dbg), 32'd1);
      wait_ack("both_ack1", 60, 1'b1);
      check("both_no_ack0", 32'(req0_ack), 32'd0);
      step();
      req1_valid = 1'b0;
      check("both_idle", 32'(state_dbg), 32'd0);
      step();
      check("both_ack0", 32'(req0_ack), 32'd1);
      check("both_ack0_only", 32'(req1_ack), 32'd0);
      check("both_ack0_upcnt", hw_up_dco_cnt, 32'h0);
      req0_valid = 1'b0;
      step();
      check("both_end_idle", 32'(state_dbg), 32'd0);

      // Stop while on: on=0 strobe, SETTLE, ack, no dcnt strobe
      req0_valid = 1'b1; req0_en = 1'b0; req0_dcnt = 4'd7;
      step();
      check("stop_dis", 32'(state_dbg), 32'd1);
      check("stop_up", hw_up_dco_ctrl, 32'h1);
      check("stop_val", hw_val_dco_ctrl, 32'h0);
      check("stop_upcnt_d", hw_up_dco_cnt, 32'h0);
      for (int i = 0; i < S; i++) begin
         step();
         check("stop_settle", 32'(state_dbg), 32'd2);
         check("stop_settle_up", hw_up_dco_ctrl | hw_up_dco_cnt, 32'h0);
      end
      step();
      check("stop_ack", 32'(req0_ack), 32'd1);
      check("stop_upcnt", hw_up_dco_cnt, 32'h0);
      check("stop_err", 32'(tune_err), 32'd0);
      req0_valid = 1'b0;
      step();

      // Fast path: stop while already off
      req1_valid = 1'b1; req1_en = 1'b0;
      step();
      check("fpoff_ack", 32'(req1_ack), 32'd1);
      check("fpoff_up", hw_up_dco_ctrl, 32'h0);
      req1_valid = 1'b0;
      step();

      // Stale DCO counter 9, new dcnt 2: restart only after the wrap
      preset_val = 4'd9; preset_go = 1'b1;
      step();
      preset_go = 1'b0;
      req0_valid = 1'b1; req0_en = 1'b1; req0_dcnt = 4'd2;
      step();                                          // T+1
      check("wrap_load", 32'(state_dbg), 32'd3);
      check("wrap_load_up", hw_up_dco_cnt, 32'hF);
      check("wrap_load_val", hw_val_dco_cnt, 32'h2);
      step();                                          // T+2
      check("wrap_en", 32'(state_dbg), 32'd4);
      check("wrap_en_val", hw_val_dco_ctrl, 32'h1);
      repeat (11) step();                              // T+13
      check("wrap_still_wait", 32'(state_dbg), 32'd5);
      check("wrap_no_ack", 32'(req0_ack), 32'd0);
      step();                                          // T+14
      check("wrap_ack", 32'(req0_ack), 32'd1);
      check("wrap_err", 32'(tune_err), 32'd0);
      req0_valid = 1'b0;
      step();

      // Timeout: DCO clock gated, 32 cycles in WAIT_EDGE
      sys_clk_en = 1'b0;
      req1_valid = 1'b1; req1_en = 1'b1; req1_dcnt = 4'd5;
      step();
      check("to_dis", 32'(state_dbg), 32'd1);
      repeat (5) step();                               // T+6
      check("to_load_val", hw_val_dco_cnt, 32'h5);
      repeat (2) step();                               // T+8
      check("to_wait_first", 32'(state_dbg), 32'd5);
      repeat (31) step();                              // T+39
      check("to_wait_last", 32'(state_dbg), 32'd5);
      check("to_no_ack", 32'(req1_ack), 32'd0);
      check("to_err_pre", 32'(tune_err), 32'd0);
      step();                                          // T+40
      check("to_ack", 32'(req1_ack), 32'd1);
      check("to_err", 32'(tune_err), 32'd1);
      req1_valid = 1'b0;
      step();
      check("to_idle", 32'(state_dbg), 32'd0);
      check("to_err_hold", 32'(tune_err), 32'd1);
      sys_clk_en = 1'b1;

      // Reset during SETTLE, then re-issue
      req0_valid = 1'b1; req0_en = 1'b1; req0_dcnt = 4'd3;
      step();
      check("mr_dis", 32'(state_dbg), 32'd1);
      check("mr_err_clr", 32'(tune_err), 32'd0);
      step(); step();
      check("mr_settle", 32'(state_dbg), 32'd2);
      sys_rst_n = 1'b0;
      #1;
      check("mr_state", 32'(state_dbg), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_up", hw_up_dco_ctrl | hw_up_dco_cnt, 32'h0);
      check("mr_val", hw_val_dco_ctrl | hw_val_dco_cnt, 32'h0);
      req0_valid = 1'b0;
      step(); step();
      sys_rst_n = 1'b1;
      step();
      check("mr_no_ack", 32'({req1_ack, req0_ack}), 32'd0);
      req0_valid = 1'b1;
      step();
      check("mr_reload", 32'(state_dbg), 32'd3);
      check("mr_reload_val", hw_val_dco_cnt, 32'h3);
      wait_ack("mr_ack", 64, 1'b0);
      check("mr_ack_err", 32'(tune_err), 32'd0);
      req0_valid = 1'b0;
      step();
      check("mr_final_idle", 32'(state_dbg), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
